controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameter FLAGS_RESET, default 4'b0000, is the NZCV value loaded on reset.
REQ-002 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 Instr  input  20  Instr[31:12]: cond[31:28], op[27:26], funct[25:20], Rd[15:12].
REQ-005 ALUFlags  input  4  {N,Z,C,V} from the current-cycle ALU result.
REQ-006 PCSrc, MemtoReg, MemWrite, ALUSrc, RegWrite  output  1 each  datapath strobes/selects.
REQ-007 RegSrc, ImmSrc, ALUControl  output  2 each  datapath selects.
REQ-008 Flags  output  4  current registered {N,Z,C,V}, for observation.

Function
REQ-009 The block SHALL be combinational from Instr/ALUFlags/Flags to outputs; the only state is the 4-bit Flags register.
REQ-010 ALUControl encoding SHALL be: 00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-011 op=00, data processing: ALUSrc=funct[5], ImmSrc=00, RegSrc=00, MemtoReg=0, RegW=1, MemW=0.
REQ-012 For data processing, cmd=funct[4:1] SHALL map 0100->ADD, 0010->SUB, 0000->AND, 1100->ORR; any other cmd SHALL force RegW=0, MemW=0, PCS=0, no flag update.
REQ-013 op=01, memory: ALUSrc=1, ImmSrc=01, ALUControl=ADD if funct[3](U)=1 else SUB.
REQ-014 LDR (funct[0]=1): MemtoReg=1, RegW=1, MemW=0, RegSrc=00; STR (funct[0]=0): MemW=1, RegW=0, RegSrc=10, MemtoReg=0.
REQ-015 op=10, branch: Branch=1, ALUSrc=1, ImmSrc=10, RegSrc=01, ALUControl=ADD, RegW=0, MemW=0, MemtoReg=0.
REQ-016 op=11 SHALL be undefined: RegW=MemW=Branch=0, no flag update; remaining selects 0.
REQ-017 PCS = Branch OR (RegW AND Rd==4'b1111).
REQ-018 Flag-write enables: FlagW[1] (N,Z) = S; FlagW[0] (C,V) = S AND ALUControl in {ADD,SUB}; S=funct[0], data processing only.
REQ-019 CondEx SHALL evaluate cond against registered Flags: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 SHALL be 0.
REQ-020 PCSrc=PCS&CondEx; RegWrite=RegW&CondEx; MemWrite=MemW&CondEx.
REQ-021 On a rising CLK with CondEx=1, N,Z SHALL load ALUFlags[3:2] if FlagW[1] and C,V SHALL load ALUFlags[1:0] if FlagW[0]; otherwise each pair holds.
REQ-022 CondEx SHALL always use pre-edge Flags; an instruction that both tests and sets flags sees old values (one-cycle latency to Flags).
REQ-023 Selects (MemtoReg, ALUSrc, RegSrc, ImmSrc, ALUControl) SHALL NOT depend on CondEx.

Reset
REQ-024 RST low SHALL set Flags=FLAGS_RESET immediately, independent of CLK.
REQ-025 While RST is low, PCSrc, RegWrite, MemWrite SHALL be 0; other outputs follow decode.
REQ-026 Reset asserted mid-instruction SHALL discard any pending flag update; the first edge after RST deasserts evaluates normally.

Structure
REQ-027 Shared package ctrl_pkg SHALL hold ALUControl codes, op codes, cond codes, cmd codes and NZCV bit indices.
REQ-028 Sub-module cond_logic SHALL contain the Flags register, CondEx evaluation and strobe gating; decode stays in controller.

Verification
REQ-029 Reset, Instr=0xE0812 (ADD AL, Rd=2): Flags=0000, RegWrite=1, ALUControl=00, PCSrc=0.
REQ-030 SUBS AL (cond 1110, funct=000101), ALUFlags=0100, edge -> Flags=0100; next BEQ (0x0A...) -> PCSrc=1, ImmSrc=10.
REQ-031 With Flags=0000, BEQ -> PCSrc=0; STRNE (cond 0001, op 01, U=1) -> MemWrite=1, RegSrc=10, ALUControl=00.
REQ-032 ANDS AL, ALUFlags=1011, prior Flags=0100 -> Flags=1000 after edge (C,V held).
REQ-033 ADD AL with Rd=15 -> PCSrc=1, RegWrite=1; cond=1111 -> all three strobes 0, Flags unchanged.
REQ-034 Flags=0100, RST pulsed low between edges -> Flags=0000 and strobes 0 before next CLK edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared encodings for the single-cycle controller: ALU, opcode,
//               condition and command codes, plus NZCV bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam logic [1:0] c_alu_add = 2'b00;
    localparam logic [1:0] c_alu_sub = 2'b01;
    localparam logic [1:0] c_alu_and = 2'b10;
    localparam logic [1:0] c_alu_orr = 2'b11;

    localparam logic [1:0] c_op_dp    = 2'b00;
    localparam logic [1:0] c_op_mem   = 2'b01;
    localparam logic [1:0] c_op_br    = 2'b10;
    localparam logic [1:0] c_op_undef = 2'b11;

    localparam logic [3:0] c_cmd_add = 4'b0100;
    localparam logic [3:0] c_cmd_sub = 4'b0010;
    localparam logic [3:0] c_cmd_and = 4'b0000;
    localparam logic [3:0] c_cmd_orr = 4'b1100;

    localparam logic [3:0] c_cond_eq = 4'b0000;
    localparam logic [3:0] c_cond_ne = 4'b0001;
    localparam logic [3:0] c_cond_cs = 4'b0010;
    localparam logic [3:0] c_cond_cc = 4'b0011;
    localparam logic [3:0] c_cond_mi = 4'b0100;
    localparam logic [3:0] c_cond_pl = 4'b0101;
    localparam logic [3:0] c_cond_vs = 4'b0110;
    localparam logic [3:0] c_cond_vc = 4'b0111;
    localparam logic [3:0] c_cond_hi = 4'b1000;
    localparam logic [3:0] c_cond_ls = 4'b1001;
    localparam logic [3:0] c_cond_ge = 4'b1010;
    localparam logic [3:0] c_cond_lt = 4'b1011;
    localparam logic [3:0] c_cond_gt = 4'b1100;
    localparam logic [3:0] c_cond_le = 4'b1101;
    localparam logic [3:0] c_cond_al = 4'b1110;
    localparam logic [3:0] c_cond_nv = 4'b1111;

    localparam int c_flag_n = 3;
    localparam int c_flag_z = 2;
    localparam int c_flag_c = 1;
    localparam int c_flag_v = 0;

    // Independent write enables for the {N,Z} and {C,V} flag pairs.
    typedef struct packed {
        logic nz;
        logic cv;
    } flag_we_t;

endpackage
`default_nettype wire

// File: rtl/controller_if.sv
`default_nettype none
// ============================================================================
// Module      : controller_if
// Description : Instruction/flag inputs and datapath control outputs of the
//               controller, bundled with master (driver) and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface controller_if;

    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCSrc;
    logic         MemtoReg;
    logic         MemWrite;
    logic         ALUSrc;
    logic         RegWrite;
    logic [1:0]   RegSrc;
    logic [1:0]   ImmSrc;
    logic [1:0]   ALUControl;
    logic [3:0]   Flags;

    modport master (
        output Instr, ALUFlags,
        input  PCSrc, MemtoReg, MemWrite, ALUSrc, RegWrite,
               RegSrc, ImmSrc, ALUControl, Flags
    );

    modport slave (
        input  Instr, ALUFlags,
        output PCSrc, MemtoReg, MemWrite, ALUSrc, RegWrite,
               RegSrc, ImmSrc, ALUControl, Flags
    );

endinterface
`default_nettype wire

// File: rtl/cond_logic.sv
`default_nettype none
// ============================================================================
// Module      : cond_logic
// Description : NZCV flag register, condition evaluation and gating of the
//               architectural write strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_logic
    import ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  wire logic     CLK,
    input  wire logic     RST,
    input  wire logic [3:0] i_cond,
    input  wire logic [3:0] i_alu_flags,
    input  wire flag_we_t i_flag_w,
    input  wire logic     i_pcs,
    input  wire logic     i_reg_w,
    input  wire logic     i_mem_w,
    output logic          o_pc_src,
    output logic          o_reg_write,
    output logic          o_mem_write,
    output logic [3:0]    o_flags
);

    logic [3:0] r_flags;
    logic       w_cond_ex;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_enable;

    assign w_n = r_flags[c_flag_n];
    assign w_z = r_flags[c_flag_z];
    assign w_c = r_flags[c_flag_c];
    assign w_v = r_flags[c_flag_v];

    always_comb begin
        w_cond_ex = 1'b0;
        case (i_cond)
            c_cond_eq: w_cond_ex = w_z;
            c_cond_ne: w_cond_ex = ~w_z;
            c_cond_cs: w_cond_ex = w_c;
            c_cond_cc: w_cond_ex = ~w_c;
            c_cond_mi: w_cond_ex = w_n;
            c_cond_pl: w_cond_ex = ~w_n;
            c_cond_vs: w_cond_ex = w_v;
            c_cond_vc: w_cond_ex = ~w_v;
            c_cond_hi: w_cond_ex = w_c & ~w_z;
            c_cond_ls: w_cond_ex = ~w_c | w_z;
            c_cond_ge: w_cond_ex = (w_n == w_v);
            c_cond_lt: w_cond_ex = (w_n != w_v);
            c_cond_gt: w_cond_ex = ~w_z & (w_n == w_v);
            c_cond_le: w_cond_ex = w_z | (w_n != w_v);
            c_cond_al: w_cond_ex = 1'b1;
            c_cond_nv: w_cond_ex = 1'b0;
            default:   w_cond_ex = 1'b0;
        endcase
    end

    // Strobes are held off for as long as reset is asserted.
    assign w_enable    = w_cond_ex & RST;
    assign o_pc_src    = i_pcs   & w_enable;
    assign o_reg_write = i_reg_w & w_enable;
    assign o_mem_write = i_mem_w & w_enable;
    assign o_flags     = r_flags;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_flags <= FLAGS_RESET;
        end else if (w_cond_ex) begin
            if (i_flag_w.nz) begin
                r_flags[c_flag_n] <= i_alu_flags[c_flag_n];
                r_flags[c_flag_z] <= i_alu_flags[c_flag_z];
            end
            if (i_flag_w.cv) begin
                r_flags[c_flag_c] <= i_alu_flags[c_flag_c];
                r_flags[c_flag_v] <= i_alu_flags[c_flag_v];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/controller.sv
`default_nettype none
// ============================================================================
// Module      : controller
// Description : Single-cycle instruction decoder; conditional execution and
//               flag storage are delegated to cond_logic.
// Revision    : 1.0 - initial release
// ============================================================================
module controller
    import ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  wire logic   CLK,
    input  wire logic   RST,
    controller_if.slave bus
);

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_rd;
    logic       w_unused_rn;

    logic       w_branch;
    logic       w_reg_w;
    logic       w_mem_w;
    logic       w_mem_to_reg;
    logic       w_alu_src;
    logic [1:0] w_reg_src;
    logic [1:0] w_imm_src;
    logic [1:0] w_alu_ctrl;
    logic       w_dp_legal;
    logic       w_pcs;
    flag_we_t   w_flag_w;

    assign w_cond      = bus.Instr[31:28];
    assign w_op        = bus.Instr[27:26];
    assign w_funct     = bus.Instr[25:20];
    assign w_rd        = bus.Instr[15:12];
    assign w_unused_rn = ^bus.Instr[19:16];

    always_comb begin
        w_branch     = 1'b0;
        w_reg_w      = 1'b0;
        w_mem_w      = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src    = 1'b0;
        w_reg_src    = 2'b00;
        w_imm_src    = 2'b00;
        w_alu_ctrl   = c_alu_add;
        w_dp_legal   = 1'b0;
        w_flag_w     = '0;
        case (w_op)
            c_op_dp: begin
                w_alu_src  = w_funct[5];
                w_dp_legal = 1'b1;
                case (w_funct[4:1])
                    c_cmd_add: w_alu_ctrl = c_alu_add;
                    c_cmd_sub: w_alu_ctrl = c_alu_sub;
                    c_cmd_and: w_alu_ctrl = c_alu_and;
                    c_cmd_orr: w_alu_ctrl = c_alu_orr;
                    default:   w_dp_legal = 1'b0;
                endcase
                w_reg_w     = w_dp_legal;
                w_flag_w.nz = w_dp_legal & w_funct[0];
                // Logical ops leave carry/overflow untouched.
                w_flag_w.cv = w_dp_legal & w_funct[0] &
                              ((w_alu_ctrl == c_alu_add) || (w_alu_ctrl == c_alu_sub));
            end
            c_op_mem: begin
                w_alu_src  = 1'b1;
                w_imm_src  = 2'b01;
                w_alu_ctrl = w_funct[3] ? c_alu_add : c_alu_sub;
                if (w_funct[0]) begin
                    w_mem_to_reg = 1'b1;
                    w_reg_w      = 1'b1;
                end else begin
                    w_mem_w   = 1'b1;
                    w_reg_src = 2'b10;
                end
            end
            c_op_br: begin
                w_branch   = 1'b1;
                w_alu_src  = 1'b1;
                w_imm_src  = 2'b10;
                w_reg_src  = 2'b01;
                w_alu_ctrl = c_alu_add;
            end
            c_op_undef: begin
                w_branch = 1'b0;
            end
            default: begin
                w_branch = 1'b0;
            end
        endcase
    end

    // A register write to R15 is a jump.
    assign w_pcs = w_branch | (w_reg_w & (w_rd == 4'b1111));

    assign bus.MemtoReg   = w_mem_to_reg;
    assign bus.ALUSrc     = w_alu_src;
    assign bus.RegSrc     = w_reg_src;
    assign bus.ImmSrc     = w_imm_src;
    assign bus.ALUControl = w_alu_ctrl;

    cond_logic #(
        .FLAGS_RESET (FLAGS_RESET)
    ) u_cond_logic (
        .CLK         (CLK),
        .RST         (RST),
        .i_cond      (w_cond),
        .i_alu_flags (bus.ALUFlags),
        .i_flag_w    (w_flag_w),
        .i_pcs       (w_pcs),
        .i_reg_w     (w_reg_w),
        .i_mem_w     (w_mem_w),
        .o_pc_src    (bus.PCSrc),
        .o_reg_write (bus.RegWrite),
        .o_mem_write (bus.MemWrite),
        .o_flags     (bus.Flags)
    );

endmodule
`default_nettype wire

// File: tb/tb_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_controller
// Description : Scoreboard bench for controller: directed cases followed by
//               random instructions checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controller;

    localparam logic [3:0] RESET_FLAGS = 4'b0000;

    typedef struct packed {
        logic [10:0] dec;
        logic [10:0] mask;
        logic [3:0]  flags;
        logic [31:0] idx;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;

    controller_if bus();

    controller #(
        .FLAGS_RESET (RESET_FLAGS)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    exp_t       q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         step_no = 0;
    logic [3:0] m_flags;
    logic [3:0] legal_cmd [4] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};

    // Condition codes come in complementary pairs: odd codes negate the even one.
    function automatic bit cond_pass(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ cond[0];
    endfunction

    function automatic bit dp_legal(input logic [3:0] cmd);
        return (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) || (cmd == 4'b1100);
    endfunction

    function automatic logic [1:0] dp_alu(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 2'b00;
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    function automatic exp_t ref_expect(input logic [19:0] ins, input logic [3:0] f,
                                        input bit in_reset, input int idx);
        exp_t e;
        logic [3:0] cond, rd;
        logic [1:0] op, rsrc, isrc, alu;
        logic [5:0] funct;
        bit go, regw, memw, br, m2r, asrc, care, pcs;
        cond = ins[19:16]; op = ins[15:14]; funct = ins[13:8]; rd = ins[3:0];
        regw = 0; memw = 0; br = 0; m2r = 0; asrc = 0; care = 1;
        rsrc = 2'b00; isrc = 2'b00; alu = 2'b00;
        case (op)
            2'b00: begin
                asrc = funct[5];
                regw = dp_legal(funct[4:1]);
                care = regw;
                alu  = dp_alu(funct[4:1]);
            end
            2'b01: begin
                asrc = 1; isrc = 2'b01;
                alu  = funct[3] ? 2'b00 : 2'b01;
                if (funct[0]) begin m2r = 1; regw = 1; end
                else begin memw = 1; rsrc = 2'b10; end
            end
            2'b10: begin
                br = 1; asrc = 1; isrc = 2'b10; rsrc = 2'b01; alu = 2'b00;
            end
            default: ;
        endcase
        go    = cond_pass(cond, f) && !in_reset;
        pcs   = br || (regw && rd == 4'd15);
        e.dec = {pcs && go, m2r, memw && go, asrc, regw && go, rsrc, isrc, alu};
        e.mask  = care ? 11'h7FF : 11'h7FC;
        e.flags = f;
        e.idx   = idx;
        return e;
    endfunction

    function automatic logic [3:0] ref_next(input logic [19:0] ins, input logic [3:0] af,
                                            input logic [3:0] f);
        logic [3:0] nf;
        logic [5:0] funct;
        nf = f;
        funct = ins[13:8];
        if (ins[15:14] == 2'b00 && dp_legal(funct[4:1]) && funct[0] && cond_pass(ins[19:16], f)) begin
            nf[3:2] = af[3:2];
            if (funct[4:1] == 4'b0100 || funct[4:1] == 4'b0010)
                nf[1:0] = af[1:0];
        end
        return nf;
    endfunction

    function automatic logic [19:0] mk(input logic [3:0] cond, input logic [1:0] op,
                                       input logic [5:0] funct, input logic [3:0] rd);
        return {cond, op, funct, 4'h0, rd};
    endfunction

    // Called just after a rising edge; returns just after the following one.
    task automatic step(input logic [19:0] ins, input logic [3:0] af, input bit rst_pulse);
        bus.Instr    = ins;
        bus.ALUFlags = af;
        if (rst_pulse) begin
            RST     = 1'b0;
            m_flags = RESET_FLAGS;
        end
        q.push_back(ref_expect(ins, m_flags, rst_pulse, step_no));
        step_no++;
        @(negedge CLK);
        #2;
        if (rst_pulse) RST = 1'b1;
        @(posedge CLK);
        m_flags = ref_next(ins, af, m_flags);
        #1;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [10:0] act;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {bus.PCSrc, bus.MemtoReg, bus.MemWrite, bus.ALUSrc, bus.RegWrite,
                       bus.RegSrc, bus.ImmSrc, bus.ALUControl};
                n_tests++;
                if ((act & e.mask) !== (e.dec & e.mask)) begin
                    n_fail++;
                    $display("FAIL decode step %0d: got %b expected %b (mask %b)",
                             e.idx, act, e.dec, e.mask);
                end
                n_tests++;
                if (bus.Flags !== e.flags) begin
                    n_fail++;
                    $display("FAIL flags step %0d: got %b expected %b", e.idx, bus.Flags, e.flags);
                end
            end
        end
    end

    initial begin : stimulus
        logic [19:0] ins;
        RST          = 1'b0;
        bus.Instr    = '0;
        bus.ALUFlags = '0;
        m_flags      = RESET_FLAGS;
        @(posedge CLK);
        #1;

        step(mk(4'hE, 2'b00, 6'b001000, 4'd2), 4'b0000, 1'b1);
        step(mk(4'hE, 2'b00, 6'b001000, 4'd2), 4'b0000, 1'b0);
        step(mk(4'hE, 2'b00, 6'b000101, 4'd3), 4'b0100, 1'b0);
        step(mk(4'h0, 2'b10, 6'b000000, 4'd0), 4'b0000, 1'b0);
        step(mk(4'hE, 2'b00, 6'b000001, 4'd1), 4'b1011, 1'b0);
        step(mk(4'hE, 2'b00, 6'b001001, 4'd1), 4'b0000, 1'b0);
        step(mk(4'h0, 2'b10, 6'b000000, 4'd0), 4'b0000, 1'b0);
        step(mk(4'h1, 2'b01, 6'b001000, 4'd4), 4'b0000, 1'b0);
        step(mk(4'hE, 2'b00, 6'b001000, 4'd15), 4'b0000, 1'b0);
        step(mk(4'hF, 2'b00, 6'b001001, 4'd15), 4'b1111, 1'b0);
        step(mk(4'hE, 2'b00, 6'b000101, 4'd3), 4'b0100, 1'b0);
        step(mk(4'hE, 2'b00, 6'b001001, 4'd15), 4'b1111, 1'b1);
        step(mk(4'h0, 2'b10, 6'b000000, 4'd0), 4'b0000, 1'b0);
        step(mk(4'h3, 2'b00, 6'b000000, 4'd2), 4'b0000, 1'b0);

        for (int i = 0; i < 400; i++) begin
            ins = 20'($urandom);
            if (ins[15:14] == 2'b00 && $urandom_range(0, 1) == 1)
                ins[12:9] = legal_cmd[$urandom_range(0, 3)];
            step(ins, 4'($urandom), $urandom_range(0, 31) == 0);
        end

        @(negedge CLK);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
